// File: rtl/common_dffram_fifo_ctrl_pkg.sv
// rtl/common_dffram_fifo_ctrl_pkg.sv - shared constants and helpers for the DFF-RAM FIFO controller
//
// Purpose: holds the RAM depth expression that the RAM and the FIFO
// controller both use, so that the two always agree on DEPTH.
// Ports: none (package).
package common_dffram_fifo_ctrl_pkg;

  // Entry count of a RAM that has addr_width address bits.
  function automatic int ram_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/common_dffram_2a1we1r.sv
// rtl/common_dffram_2a1we1r.sv - DFF-based simple dual-port RAM, one write port, one async read port
//
// Purpose: flop-array storage with a synchronous bit-masked write port (A)
// and a combinational read port (B). Synchronous reset returns every entry
// to RAM_RESET_VALUE.
// Ports:
//   clk    - clock, writes take effect on the rising edge
//   reset  - synchronous active-high reset, clears every entry
//   addra  - write address
//   ena    - write enable
//   wea    - per-bit write mask, 1 = bit is written
//   dina   - write data
//   addrb  - read address
//   doutb  - read data, combinational from addrb
module common_dffram_2a1we1r
  import common_dffram_fifo_ctrl_pkg::*;
#(
  parameter int                    RAM_DATA_WIDTH  = 8,
  parameter int                    RAM_ADDR_WIDTH  = 2,
  parameter logic [RAM_DATA_WIDTH-1:0] RAM_RESET_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [RAM_ADDR_WIDTH-1:0] addra,
  input  logic                      ena,
  input  logic [RAM_DATA_WIDTH-1:0] wea,
  input  logic [RAM_DATA_WIDTH-1:0] dina,
  input  logic [RAM_ADDR_WIDTH-1:0] addrb,
  output logic [RAM_DATA_WIDTH-1:0] doutb
);

  localparam int RAM_DEPTH = ram_depth(RAM_ADDR_WIDTH);

  logic [RAM_DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_DEPTH; i++) begin
        mem_q[i] <= RAM_RESET_VALUE;
      end
    end else if (ena) begin
      // Masked write: untouched bits keep their old contents.
      mem_q[addra] <= (mem_q[addra] & ~wea) | (dina & wea);
    end
  end

  assign doutb = mem_q[addrb];

endmodule

// File: rtl/common_dffram_fifo_ctrl.sv
// rtl/common_dffram_fifo_ctrl.sv - synchronous FWFT FIFO controller around the DFF RAM
//
// Purpose: drives the RAM write/read ports from valid/ready push and pop
// handshakes; provides fall-through head data, occupancy, status flags and
// a synchronous flush.
// Ports:
//   clk, reset         - clock and synchronous active-high reset
//   s_valid/s_ready    - push handshake, s_ready = !full
//   s_data             - push data
//   m_valid/m_ready    - pop handshake, m_valid = !empty
//   m_data             - head entry, combinational from the RAM read port
//   flush              - discards all entries on the next edge
//   count              - occupancy 0..DEPTH
//   empty/full         - occupancy flags
//   almost_full        - count >= ALMOST_FULL_LEVEL
module common_dffram_fifo_ctrl
  import common_dffram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 2,
  parameter int ALMOST_FULL_LEVEL = (1 << ADDR_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full
);

  localparam int                DEPTH    = ram_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;

  logic push;
  logic pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                 (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
  assign almost_full = (count_q >= AF_LEVEL);
  assign count   = count_q;
  assign s_ready = !full;
  assign m_valid = !empty;

  assign push = s_valid & s_ready;
  assign pop  = m_valid & m_ready;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  common_dffram_2a1we1r #(
    .RAM_DATA_WIDTH (DATA_WIDTH),
    .RAM_ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .addra (wptr_q[ADDR_WIDTH-1:0]),
    .ena   (push & !flush),
    .wea   ({DATA_WIDTH{1'b1}}),
    .dina  (s_data),
    .addrb (rptr_q[ADDR_WIDTH-1:0]),
    .doutb (m_data)
  );

endmodule
